// File: rtl/bus_arbiter.sv
// Round-robin arbiter in front of a single server: grants one client at a time,
// forwards its transaction, returns a one-cycle ack with registered read data.
// Ports: clk/reset; client side rq, address, wr_ni, dataW -> ack, dataR, grant, busy;
// server side srv_rq, srv_addr, srv_wr_ni, srv_dataW <- srv_ack, srv_dataR.
// Optional macro ARB_TIMEOUT_EN adds a BUSY watchdog and a one-cycle timeout pulse.
module bus_arbiter #(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 4,
    parameter int NUM_CLIENTS    = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_CLIENTS-1:0]            rq,
    input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] address,
    input  logic [NUM_CLIENTS-1:0]            wr_ni,
    input  logic [NUM_CLIENTS*DATA_WIDTH-1:0] dataW,
    output logic [NUM_CLIENTS-1:0]            ack,
    output logic [DATA_WIDTH-1:0]             dataR,
    output logic [NUM_CLIENTS-1:0]            grant,
    output logic                              busy,
`ifdef ARB_TIMEOUT_EN
    output logic                              timeout,
`endif
    output logic                              srv_rq,
    output logic [ADDR_WIDTH-1:0]             srv_addr,
    output logic                              srv_wr_ni,
    output logic [DATA_WIDTH-1:0]             srv_dataW,
    input  logic                              srv_ack,
    input  logic [DATA_WIDTH-1:0]             srv_dataR
);

    localparam int IW = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
    localparam logic [NUM_CLIENTS-1:0] ONE = NUM_CLIENTS'(1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                  state, state_n;
    logic [IW-1:0]           idx, idx_n;
    logic [IW-1:0]           last, last_n;
    logic [IW-1:0]           sel;
    logic [IW-1:0]           cand;
    logic                    found;
    logic [NUM_CLIENTS-1:0]  grant_n;
    logic [DATA_WIDTH-1:0]   dataR_n;
    int                      j;

`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt, cnt_n;
    logic          timeout_n;
`endif

    // First requester strictly after the last completed owner, with wrap.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        cand  = '0;
        j     = 0;
        for (int k = 1; k <= NUM_CLIENTS; k++) begin
            j    = (int'(last) + k) % NUM_CLIENTS;
            cand = IW'(j);
            if (!found && rq[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    always_comb begin
        state_n = state;
        idx_n   = idx;
        last_n  = last;
        grant_n = grant;
        dataR_n = dataR;
`ifdef ARB_TIMEOUT_EN
        cnt_n     = cnt;
        timeout_n = 1'b0;
`endif
        unique case (state)
            IDLE: begin
                if (found) begin
                    state_n = BUSY;
                    idx_n   = sel;
                    grant_n = ONE << sel;
`ifdef ARB_TIMEOUT_EN
                    cnt_n = '0;
`endif
                end
            end
            BUSY: begin
                // srv_ack takes precedence over an abandon in the same cycle.
                if (srv_ack) begin
                    dataR_n = srv_dataR;
                    last_n  = idx;
                    state_n = DONE;
                end else if (!rq[idx]) begin
                    state_n = IDLE;
                    grant_n = '0;
                end
`ifdef ARB_TIMEOUT_EN
                else begin
                    cnt_n = cnt + CW'(1);
                    if (cnt_n == CW'(TIMEOUT_CYCLES)) begin
                        // Treat the stalled owner as served so it loses priority.
                        state_n   = IDLE;
                        grant_n   = '0;
                        last_n    = idx;
                        timeout_n = 1'b1;
                    end
                end
`endif
            end
            DONE: begin
                state_n = IDLE;
                grant_n = '0;
            end
            default: begin
                state_n = IDLE;
                grant_n = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            idx   <= '0;
            last  <= IW'(NUM_CLIENTS - 1);
            grant <= '0;
            dataR <= '0;
`ifdef ARB_TIMEOUT_EN
            cnt     <= '0;
            timeout <= 1'b0;
`endif
        end else begin
            state <= state_n;
            idx   <= idx_n;
            last  <= last_n;
            grant <= grant_n;
            dataR <= dataR_n;
`ifdef ARB_TIMEOUT_EN
            cnt     <= cnt_n;
            timeout <= timeout_n;
`endif
        end
    end

    assign srv_rq    = (state == BUSY);
    assign busy      = (state != IDLE);
    assign ack       = (state == DONE) ? grant : '0;
    assign srv_addr  = srv_rq ? address[int'(idx)*ADDR_WIDTH +: ADDR_WIDTH] : '0;
    assign srv_dataW = srv_rq ? dataW[int'(idx)*DATA_WIDTH +: DATA_WIDTH] : '0;
    assign srv_wr_ni = srv_rq & wr_ni[idx];

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Round-robin arbiter that sits directly downstream of the client blocks and upstream of the single server.
- Collects rq/address/wr_ni/dataW from NUM_CLIENTS clients and grants exactly one client at a time.
- Forwards the granted transaction to the server, then returns a one-cycle ack and registered dataR to the granted client.
- Provides fair, starvation-free access to the shared server.

Parameters:
- DATA_WIDTH, 8, width of the write/read data buses.
- ADDR_WIDTH, 4, width of the address bus.
- NUM_CLIENTS, 4, number of requesters (2..8).
- TIMEOUT_CYCLES, 16, cycles in BUSY without srv_ack before abort (used only with ARB_TIMEOUT_EN).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous reset, active-high.
- rq  input  NUM_CLIENTS  per-client request; bit i belongs to client i.
- address  input  NUM_CLIENTS*ADDR_WIDTH  flattened client addresses; client i at [i*ADDR_WIDTH +: ADDR_WIDTH].
- wr_ni  input  NUM_CLIENTS  per-client direction; 1 = read, 0 = write.
- dataW  input  NUM_CLIENTS*DATA_WIDTH  flattened client write data.
- ack  output  NUM_CLIENTS  one-hot, single-cycle completion pulse to the granted client.
- dataR  output  DATA_WIDTH  registered read data, broadcast to all clients; valid while ack is high.
- grant  output  NUM_CLIENTS  one-hot current owner; all zeros when not owned.
- busy  output  1  high in the BUSY and DONE states.
- srv_rq  output  1  request to the server.
- srv_addr  output  ADDR_WIDTH  address of the granted client.
- srv_wr_ni  output  1  direction of the granted client.
- srv_dataW  output  DATA_WIDTH  write data of the granted client.
- srv_ack  input  1  server completion, one cycle.
- srv_dataR  input  DATA_WIDTH  server read data, valid with srv_ack.

Behaviour:
- Reset: state=IDLE, grant=0, ack=0, dataR=0, srv_rq=0, busy=0, last pointer = NUM_CLIENTS-1, so client 0 has first priority.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - If rq is nonzero, select the first set bit scanning from (last+1) mod NUM_CLIENTS upward with wrap.
  - Register grant (one-hot) and idx; go to BUSY.
  - Otherwise stay in IDLE.
- BUSY:
  - srv_rq=1.
  - srv_addr, srv_wr_ni and srv_dataW are combinationally muxed from client idx.
  - If srv_ack=1: capture srv_dataR into dataR, set last=idx, go to DONE.
  - If srv_ack=0 and rq[idx]=0 (client abandoned): go to IDLE with no ack; last is unchanged.
  - srv_ack and abandon in the same cycle: srv_ack wins.
- DONE:
  - ack[idx]=1 for exactly this cycle; srv_rq=0; grant is held.
  - Next state is IDLE; grant clears on entry to IDLE.
- Outside BUSY: srv_addr, srv_wr_ni and srv_dataW are driven 0. srv_ack outside BUSY is ignored.
- Latency:
  - rq seen in IDLE at cycle 0; srv_rq high from cycle 1.
  - srv_ack at cycle k (k>=1) gives ack at cycle k+1; back in IDLE at k+2.
  - Minimum rq-to-ack latency is 2 cycles.
- Fairness:
  - The pointer advances only on completed transactions.
  - A client that keeps rq high after its ack loses priority to every other requester.
  - Worst-case wait is NUM_CLIENTS-1 transactions.
- dataR holds its last captured value until the next srv_ack in BUSY. Write transactions also capture srv_dataR.
- Reset asserted mid-transaction returns everything to reset values immediately; no ack is issued.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- With the macro defined:
  - A counter of $clog2(TIMEOUT_CYCLES+1) bits clears on entry to BUSY and increments each BUSY cycle without srv_ack.
  - When the counter reaches TIMEOUT_CYCLES: go to IDLE, no ack, last=idx so the client is de-prioritised, and pulse output port timeout (1 bit, reset 0) for one cycle.
- Without the macro: the timeout port and counter do not exist, and BUSY waits indefinitely for srv_ack or abandon.

Test Plan:
- Single request: rq=0001, address0=4'h3, wr_ni0=1; server acks on the 2nd BUSY cycle with srv_dataR=8'hA5 -> srv_addr=3, srv_wr_ni=1; ack=0001 one cycle later; dataR=8'hA5 while ack is high.
- Contention: rq=1111 held continuously, server acks every first BUSY cycle -> grant order 0001, 0010, 0100, 1000, 0001; each ack is one cycle, 3 cycles apart.
- Mux check: rq=0100, dataW2=8'h3C, wr_ni2=0 -> srv_dataW=8'h3C and srv_wr_ni=0 during BUSY; srv_dataW=0 in IDLE/DONE.
- Abandon: grant=0010 in BUSY, rq[1] drops before srv_ack -> IDLE next cycle, ack stays 0, and the next grant with rq=0011 is 0010 (pointer not advanced).
- Reset mid-BUSY: assert reset while srv_rq=1 -> srv_rq, grant, ack, dataR and busy are 0 immediately; after release with rq=1000 -> first grant is 1000.
- With ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16: srv_ack is never asserted -> timeout pulses after 16 BUSY cycles and the FSM is in IDLE; with rq=0011 and grant=0001 at the timeout, the next grant is 0010.
